// File: rtl/pulpino_run_ctrl_if.sv
// Board-side control/status bundle for the PULPino run sequencer.
interface pulpino_run_ctrl_if #(
  parameter int unsigned CNT_WIDTH = 32
);
  logic                 start_i;
  logic                 abort_i;
  logic                 load_done_i;
  logic                 eoc_i;
  logic                 core_rst_no;
  logic                 fetch_enable_o;
  logic                 busy_o;
  logic                 done_o;
  logic                 timeout_o;
  logic [CNT_WIDTH-1:0] cycle_count_o;

  modport master (
    output start_i, abort_i, load_done_i, eoc_i,
    input  core_rst_no, fetch_enable_o, busy_o, done_o, timeout_o, cycle_count_o
  );

  modport slave (
    input  start_i, abort_i, load_done_i, eoc_i,
    output core_rst_no, fetch_enable_o, busy_o, done_o, timeout_o, cycle_count_o
  );
endinterface

// File: rtl/pulpino_run_ctrl.sv
// Run sequencer for the PULPino core: reset hold, wait for program load,
// fetch-enable delay, run until end-of-computation or timeout.
module pulpino_run_ctrl #(
  parameter int unsigned RST_HOLD_CYCLES    = 12,
  parameter int unsigned FETCH_DELAY_CYCLES = 5,
  parameter int unsigned TIMEOUT_CYCLES     = 0,
  parameter int unsigned CNT_WIDTH          = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  pulpino_run_ctrl_if.slave ctrl
);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_RESET_HOLD  = 3'd1;
  localparam logic [2:0] S_WAIT_LOAD   = 3'd2;
  localparam logic [2:0] S_FETCH_DELAY = 3'd3;
  localparam logic [2:0] S_RUN         = 3'd4;
  localparam logic [2:0] S_DONE        = 3'd5;
  localparam logic [2:0] S_TIMEOUT     = 3'd6;

  localparam int unsigned DLY_MAX = (RST_HOLD_CYCLES > FETCH_DELAY_CYCLES) ?
                                    RST_HOLD_CYCLES : FETCH_DELAY_CYCLES;
  localparam int unsigned DLY_W   = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;
  localparam int unsigned TO_LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  localparam logic [DLY_W-1:0]     RST_LAST = DLY_W'(RST_HOLD_CYCLES - 1);
  localparam logic [DLY_W-1:0]     FD_LAST  = DLY_W'(FETCH_DELAY_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TO_LAST  = CNT_WIDTH'(TO_LAST_I);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  logic [2:0]           state, state_d;
  logic [DLY_W-1:0]     dly, dly_d;
  logic [CNT_WIDTH-1:0] cnt, cnt_d;
  logic                 eoc_meta, eoc_s;
  logic                 core_rst_n_q, core_rst_n_d;
  logic                 fetch_en_q, fetch_en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 timeout_q, timeout_d;
  logic                 start_ok;

  // abort suppresses a simultaneous start, so the count is never cleared by it
  assign start_ok = ctrl.start_i && !ctrl.abort_i;

  // Next state, counters and Moore outputs decoded from the next state
  always_comb begin
    state_d = state;
    dly_d   = dly;
    cnt_d   = cnt;

    case (state)
      S_IDLE: begin
        if (start_ok) begin
          state_d = S_RESET_HOLD;
          dly_d   = '0;
          cnt_d   = '0;
        end
      end
      S_RESET_HOLD: begin
        if (dly == RST_LAST) begin
          state_d = S_WAIT_LOAD;
          dly_d   = '0;
        end else begin
          dly_d = dly + DLY_W'(1);
        end
      end
      S_WAIT_LOAD: begin
        if (ctrl.load_done_i) begin
          state_d = S_FETCH_DELAY;
          dly_d   = '0;
        end
      end
      S_FETCH_DELAY: begin
        if (dly == FD_LAST) begin
          state_d = S_RUN;
          dly_d   = '0;
        end else begin
          dly_d = dly + DLY_W'(1);
        end
      end
      S_RUN: begin
        if (cnt != CNT_MAX) begin
          cnt_d = cnt + CNT_WIDTH'(1);
        end
        if (eoc_s) begin
          state_d = S_DONE;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt == TO_LAST)) begin
          state_d = S_TIMEOUT;
        end
      end
      S_DONE, S_TIMEOUT: begin
        if (start_ok) begin
          state_d = S_RESET_HOLD;
          dly_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (ctrl.abort_i) begin
      state_d = S_IDLE;
      dly_d   = '0;
    end

    core_rst_n_d = (state_d != S_IDLE) && (state_d != S_RESET_HOLD);
    fetch_en_d   = (state_d == S_RUN);
    busy_d       = (state_d == S_RESET_HOLD) || (state_d == S_WAIT_LOAD) ||
                   (state_d == S_FETCH_DELAY) || (state_d == S_RUN);
    done_d       = (state_d == S_DONE);
    timeout_d    = (state_d == S_TIMEOUT);
  end

  // State, counters, eoc synchronizer and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      dly          <= '0;
      cnt          <= '0;
      eoc_meta     <= 1'b0;
      eoc_s        <= 1'b0;
      core_rst_n_q <= 1'b0;
      fetch_en_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state        <= state_d;
      dly          <= dly_d;
      cnt          <= cnt_d;
      eoc_meta     <= ctrl.eoc_i;
      eoc_s        <= eoc_meta;
      core_rst_n_q <= core_rst_n_d;
      fetch_en_q   <= fetch_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
    end
  end

  assign ctrl.core_rst_no    = core_rst_n_q;
  assign ctrl.fetch_enable_o = fetch_en_q;
  assign ctrl.busy_o         = busy_q;
  assign ctrl.done_o         = done_q;
  assign ctrl.timeout_o      = timeout_q;
  assign ctrl.cycle_count_o  = cnt;

endmodule

// File: tb/tb_pulpino_run_ctrl.sv
// Self-checking bench for pulpino_run_ctrl: scenario table, random runs
// against a timeline model, async reset and counter saturation sequences.
module tb_pulpino_run_ctrl;

  localparam int H  = 4;
  localparam int F  = 3;
  localparam int T  = 100;
  localparam int CW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pulpino_run_ctrl_if #(.CNT_WIDTH(CW)) bus ();
  pulpino_run_ctrl_if #(.CNT_WIDTH(4))  bus2 ();

  pulpino_run_ctrl #(
    .RST_HOLD_CYCLES(H), .FETCH_DELAY_CYCLES(F),
    .TIMEOUT_CYCLES(T), .CNT_WIDTH(CW)
  ) dut (.clk(clk), .rst_n(rst_n), .ctrl(bus));

  pulpino_run_ctrl #(
    .RST_HOLD_CYCLES(1), .FETCH_DELAY_CYCLES(1),
    .TIMEOUT_CYCLES(0), .CNT_WIDTH(4)
  ) dut2 (.clk(clk), .rst_n(rst_n), .ctrl(bus2));

  typedef struct packed {
    logic        rst;
    logic        fe;
    logic        busy;
    logic        done;
    logic        to;
    logic [31:0] cnt;
  } obs_t;

  // w: extra cycles load_done stays low in WAIT_LOAD; e: eoc_i rises after
  // edge R+e (-1 = never); a: abort sampled at edge a (0 = none)
  typedef struct {
    int w;
    int e;
    int a;
    bit has_exp;
    bit exp_done;
    bit exp_to;
    int exp_cnt;
  } scen_t;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic obs_t observe();
    obs_t o;
    o.rst  = bus.core_rst_no;
    o.fe   = bus.fetch_enable_o;
    o.busy = bus.busy_o;
    o.done = bus.done_o;
    o.to   = bus.timeout_o;
    o.cnt  = bus.cycle_count_o;
    return o;
  endfunction

  function automatic obs_t observe2();
    obs_t o;
    o.rst  = bus2.core_rst_no;
    o.fe   = bus2.fetch_enable_o;
    o.busy = bus2.busy_o;
    o.done = bus2.done_o;
    o.to   = bus2.timeout_o;
    o.cnt  = 32'(bus2.cycle_count_o);
    return o;
  endfunction

  function automatic obs_t mk(input bit rst, input bit fe, input bit busy,
                              input bit done, input bit to, input int cnt);
    obs_t o;
    o.rst = rst; o.fe = fe; o.busy = busy; o.done = done; o.to = to;
    o.cnt = 32'(cnt);
    return o;
  endfunction

  function automatic bool_done(input scen_t s);
    return (s.e >= 0) && (s.e + 3 <= T);
  endfunction

  // Edge (relative to the start edge) at which the run ends
  function automatic int fin_of(input scen_t s);
    int r;
    r = H + 1 + s.w + F;
    if ((s.e >= 0) && (s.e + 3 <= T)) return r + s.e + 3;
    return r + T;
  endfunction

  // Expected outputs just after relative edge t, from the timing rules
  function automatic obs_t model(input scen_t s, input int t);
    obs_t o;
    int l, r, fin;
    l   = H + 1 + s.w;
    r   = l + F;
    fin = fin_of(s);
    o   = '0;
    if (s.a != 0 && t >= s.a) begin
      if (s.a > r) o.cnt = 32'(s.a - r);
    end else if (t < H) begin
      o.busy = 1'b1;
    end else if (t < fin) begin
      o.rst  = 1'b1;
      o.busy = 1'b1;
      if (t >= r) begin
        o.fe  = 1'b1;
        o.cnt = 32'(t - r);
      end
    end else begin
      o.rst = 1'b1;
      o.cnt = 32'(fin - r);
      if ((s.e >= 0) && (s.e + 3 <= T)) o.done = 1'b1;
      else                              o.to   = 1'b1;
    end
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_scen(input scen_t s, input int idx);
    int l, r, fin, stop, last;
    l    = H + 1 + s.w;
    r    = l + F;
    fin  = fin_of(s);
    stop = (s.a != 0) ? s.a : fin;
    last = stop + 3;
    bus.start_i     = 1'b1;
    bus.abort_i     = 1'b0;
    bus.load_done_i = 1'b0;
    bus.eoc_i       = 1'b0;
    for (int t = 0; t <= last; t++) begin
      step();
      chk($sformatf("scen%0d t=%0d", idx, t), 64'(observe()), 64'(model(s, t)));
      bus.start_i     = (t + 1 <= stop) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.abort_i     = (t + 1 == s.a);
      bus.load_done_i = (t + 1 <= H) ? 1'($urandom_range(0, 1)) : (t + 1 >= l);
      bus.eoc_i       = (s.e >= 0) && (t + 1 > r + s.e);
    end
    if (s.has_exp) begin
      chk($sformatf("scen%0d final", idx),
          64'({bus.done_o, bus.timeout_o, bus.cycle_count_o}),
          64'({s.exp_done, s.exp_to, 32'(s.exp_cnt)}));
    end
    bus.start_i     = 1'b0;
    bus.abort_i     = 1'b0;
    bus.load_done_i = 1'b0;
    bus.eoc_i       = 1'b0;
    repeat (3) step();
  endtask

  scen_t tbl[9];

  initial begin
    scen_t s;
    int    fin;

    // {w, e, a, has_exp, exp_done, exp_to, exp_cnt}
    tbl[0] = '{0,   50, 0,  1'b1, 1'b1, 1'b0, 53};   // nominal run
    tbl[1] = '{200, 10, 0,  1'b1, 1'b1, 1'b0, 13};   // long load wait
    tbl[2] = '{0,   -1, 0,  1'b1, 1'b0, 1'b1, 100};  // timeout
    tbl[3] = '{0,   97, 0,  1'b1, 1'b1, 1'b0, 100};  // eoc_s with timeout: done wins
    tbl[4] = '{0,   98, 0,  1'b1, 1'b0, 1'b1, 100};  // eoc one cycle too late
    tbl[5] = '{0,   50, 28, 1'b1, 1'b0, 1'b0, 20};   // abort in RUN
    tbl[6] = '{0,   50, 2,  1'b1, 1'b0, 1'b0, 0};    // abort in RESET_HOLD
    tbl[7] = '{5,   50, 7,  1'b1, 1'b0, 1'b0, 0};    // abort in WAIT_LOAD
    tbl[8] = '{0,   5,  0,  1'b1, 1'b1, 1'b0, 8};    // clean restart after abort

    bus.start_i = 1'b0;  bus.abort_i = 1'b0;  bus.load_done_i = 1'b0;  bus.eoc_i = 1'b0;
    bus2.start_i = 1'b0; bus2.abort_i = 1'b0; bus2.load_done_i = 1'b0; bus2.eoc_i = 1'b0;

    #12;
    chk("reset_values", 64'(observe()), 64'(obs_t'('0)));
    rst_n = 1'b1;
    step();
    chk("idle_after_reset", 64'(observe()), 64'(obs_t'('0)));

    for (int i = 0; i < 9; i++) run_scen(tbl[i], i);

    // Async reset in the middle of a run
    bus.start_i = 1'b1;
    step();
    bus.start_i     = 1'b0;
    bus.load_done_i = 1'b1;
    repeat (20) step();
    chk("running_before_rst", 64'(observe()), 64'(mk(1, 1, 1, 0, 0, 12)));
    #3 rst_n = 1'b0;
    #1 chk("async_rst_outputs", 64'(observe()), 64'(obs_t'('0)));
    #2 rst_n = 1'b1;
    step();
    chk("idle_after_async_rst", 64'(observe()), 64'(obs_t'('0)));
    bus.load_done_i = 1'b0;
    step();

    for (int i = 0; i < 25; i++) begin
      s.w       = int'($urandom_range(0, 20));
      s.e       = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 110));
      s.a       = 0;
      s.has_exp = 1'b0;
      s.exp_done = 1'b0;
      s.exp_to   = 1'b0;
      s.exp_cnt  = 0;
      fin = fin_of(s);
      if ($urandom_range(0, 3) == 0) s.a = int'($urandom_range(1, 32'(fin - 1)));
      run_scen(s, 100 + i);
    end

    // Minimal delays and 4-bit counter saturation on the second instance
    bus2.start_i = 1'b1;
    step();
    chk("d2_reset_hold", 64'(observe2()), 64'(mk(0, 0, 1, 0, 0, 0)));
    bus2.start_i     = 1'b0;
    bus2.load_done_i = 1'b1;
    step();
    chk("d2_wait_load", 64'(observe2()), 64'(mk(1, 0, 1, 0, 0, 0)));
    step();
    chk("d2_fetch_delay", 64'(observe2()), 64'(mk(1, 0, 1, 0, 0, 0)));
    step();
    chk("d2_run_start", 64'(observe2()), 64'(mk(1, 1, 1, 0, 0, 0)));
    repeat (15) step();
    chk("d2_cnt_max", 64'(observe2()), 64'(mk(1, 1, 1, 0, 0, 15)));
    repeat (25) step();
    chk("d2_cnt_saturated", 64'(observe2()), 64'(mk(1, 1, 1, 0, 0, 15)));
    bus2.eoc_i = 1'b1;
    repeat (2) step();
    chk("d2_eoc_in_sync", 64'(observe2()), 64'(mk(1, 1, 1, 0, 0, 15)));
    step();
    chk("d2_done", 64'(observe2()), 64'(mk(1, 0, 0, 1, 0, 15)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
